// File: rtl/mandelbrot_pkg.sv
// Shared constants and types for the Mandelbrot coordinate generator.
package mandelbrot_pkg;

    localparam int unsigned WIDTH     = 32;
    localparam int unsigned FRAC_BITS = 22;
    localparam int unsigned ITER_W    = 8;

    localparam logic [WIDTH-1:0] FIX_ONE   = 32'h0040_0000;
    localparam logic [WIDTH-1:0] ESCAPE_SQ = 32'h0100_0000;

    typedef logic signed [WIDTH-1:0] fix_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } cg_state_t;

endpackage

// File: rtl/mandelbrot_raster_cnt.sv
// Raster x/y position counter: x wraps at end of line, y wraps at end of frame.
module mandelbrot_raster_cnt #(
    parameter int unsigned H_RES = 640,
    parameter int unsigned V_RES = 480,
    parameter int unsigned XW    = 10,
    parameter int unsigned YW    = 9
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          advance,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          eol_c,
    output logic          eof_c
);

    localparam logic [XW-1:0] X_MAX = XW'(H_RES - 1);
    localparam logic [YW-1:0] Y_MAX = YW'(V_RES - 1);

    assign eol_c = (x == X_MAX);
    assign eof_c = eol_c & (y == Y_MAX);

    // Position register: clear wins over advance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x <= '0;
            y <= '0;
        end else if (clear) begin
            x <= '0;
            y <= '0;
        end else if (advance) begin
            if (eol_c) begin
                x <= '0;
                y <= eof_c ? '0 : y + YW'(1);
            end else begin
                x <= x + XW'(1);
            end
        end
    end

endmodule

// File: rtl/mandelbrot_coord_gen.sv
// Raster coordinate source for the Mandelbrot iteration pipeline.
// Optional continuous (back-to-back frame) mode: MANDELBROT_CONT_EN.
module mandelbrot_coord_gen
    import mandelbrot_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned H_RES = 640,
    parameter int unsigned V_RES = 480,
    parameter int unsigned XW    = 10,
    parameter int unsigned YW    = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [WIDTH-1:0]  origin_real,
    input  logic [WIDTH-1:0]  origin_imag,
    input  logic [WIDTH-1:0]  step,
    output logic              busy,
    output logic              done,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  c_real,
    output logic [WIDTH-1:0]  c_imag,
    output logic [WIDTH-1:0]  z_real,
    output logic [WIDTH-1:0]  z_imag,
    output logic [ITER_W-1:0] iters,
    output logic [XW-1:0]     pix_x,
    output logic [YW-1:0]     pix_y,
    output logic              last
);

    cg_state_t        state, state_nxt;
    logic             busy_nxt, done_nxt, valid_nxt;
    logic [WIDTH-1:0] c_real_nxt, c_imag_nxt;
    logic [WIDTH-1:0] cfg_or, cfg_oi, cfg_step;
    logic [WIDTH-1:0] cfg_or_nxt, cfg_oi_nxt, cfg_step_nxt;
    logic             cnt_clear, cnt_advance;
    logic             eol_c, eof_c;
    logic             accept;
`ifdef MANDELBROT_CONT_EN
    logic [WIDTH-1:0] sh_or, sh_oi, sh_step;
    logic [WIDTH-1:0] sh_or_nxt, sh_oi_nxt, sh_step_nxt;
    logic             pend, pend_nxt;
`endif

    assign z_real = '0;
    assign z_imag = '0;
    assign iters  = '0;
    assign accept = out_valid & out_ready;
    assign last   = eof_c & out_valid;

    mandelbrot_raster_cnt #(
        .H_RES (H_RES),
        .V_RES (V_RES),
        .XW    (XW),
        .YW    (YW)
    ) u_cnt (
        .clk     (clk),
        .rst     (rst),
        .clear   (cnt_clear),
        .advance (cnt_advance),
        .x       (pix_x),
        .y       (pix_y),
        .eol_c   (eol_c),
        .eof_c   (eof_c)
    );

    // Next-state and datapath update: c_real restarts from the latched origin each line.
    always_comb begin
        state_nxt    = state;
        busy_nxt     = busy;
        done_nxt     = 1'b0;
        valid_nxt    = out_valid;
        c_real_nxt   = c_real;
        c_imag_nxt   = c_imag;
        cfg_or_nxt   = cfg_or;
        cfg_oi_nxt   = cfg_oi;
        cfg_step_nxt = cfg_step;
        cnt_clear    = 1'b0;
        cnt_advance  = 1'b0;
`ifdef MANDELBROT_CONT_EN
        sh_or_nxt    = sh_or;
        sh_oi_nxt    = sh_oi;
        sh_step_nxt  = sh_step;
        pend_nxt     = pend;
`endif
        case (state)
            IDLE: begin
                if (start) begin
                    cfg_or_nxt   = origin_real;
                    cfg_oi_nxt   = origin_imag;
                    cfg_step_nxt = step;
                    c_real_nxt   = origin_real;
                    c_imag_nxt   = origin_imag;
                    cnt_clear    = 1'b1;
                    state_nxt    = RUN;
                    busy_nxt     = 1'b1;
                    valid_nxt    = 1'b1;
                end
            end
            RUN: begin
`ifdef MANDELBROT_CONT_EN
                if (start) begin
                    sh_or_nxt   = origin_real;
                    sh_oi_nxt   = origin_imag;
                    sh_step_nxt = step;
                    pend_nxt    = 1'b1;
                end
`endif
                if (accept) begin
                    cnt_advance = 1'b1;
                    if (!eol_c) begin
                        c_real_nxt = c_real + cfg_step;
                    end else if (!eof_c) begin
                        c_real_nxt = cfg_or;
                        c_imag_nxt = c_imag - cfg_step;
                    end else begin
                        done_nxt = 1'b1;
`ifdef MANDELBROT_CONT_EN
                        // Roll straight into the next frame, adopting any pending config.
                        if (pend) begin
                            cfg_or_nxt   = sh_or;
                            cfg_oi_nxt   = sh_oi;
                            cfg_step_nxt = sh_step;
                            c_real_nxt   = sh_or;
                            c_imag_nxt   = sh_oi;
                            pend_nxt     = start;
                        end else begin
                            c_real_nxt = cfg_or;
                            c_imag_nxt = cfg_oi;
                        end
`else
                        state_nxt = IDLE;
                        busy_nxt  = 1'b0;
                        valid_nxt = 1'b0;
`endif
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, output and configuration registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            out_valid <= 1'b0;
            c_real    <= '0;
            c_imag    <= '0;
            cfg_or    <= '0;
            cfg_oi    <= '0;
            cfg_step  <= '0;
`ifdef MANDELBROT_CONT_EN
            sh_or     <= '0;
            sh_oi     <= '0;
            sh_step   <= '0;
            pend      <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            out_valid <= valid_nxt;
            c_real    <= c_real_nxt;
            c_imag    <= c_imag_nxt;
            cfg_or    <= cfg_or_nxt;
            cfg_oi    <= cfg_oi_nxt;
            cfg_step  <= cfg_step_nxt;
`ifdef MANDELBROT_CONT_EN
            sh_or     <= sh_or_nxt;
            sh_oi     <= sh_oi_nxt;
            sh_step   <= sh_step_nxt;
            pend      <= pend_nxt;
`endif
        end
    end

endmodule
